output_neuron_mac: RTL and testbench
====================================

// Module: output_neuron_mac
// PURPOSE
//  Output-layer neuron; sits directly downstream of the hidden_neuron stage.
//  Serially consumes NUM_HIDDEN hidden activations (10-bit unsigned Q3.7), one per accepted beat.
//  Multiplies each activation by a signed Q1.7 weight, accumulates, adds the bias, applies ReLU,
//  then saturates to 10-bit Q3.7.
//  Presents the result and a threshold "fire" bit on a valid/ready output port.
// PARAMETERS
//  NUM_HIDDEN  4        number of hidden activations per inference (>=2)
//  THRESH      10'd64   fire_o threshold on neuron_o, Q3.7 (64 = 0.5)
// PORTS
//  clk_i           in   1               single clock, rising edge
//  rst_i           in   1               synchronous, active-high reset
//  start_i         in   1               begin one inference (honoured in IDLE only)
//  hidden_valid_i  in   1               hidden_i carries a valid activation
//  hidden_ready_o  out  1               block accepts hidden_i this cycle
//  hidden_i        in   10              hidden activation, unsigned Q3.7
//  weights_i       in   8*NUM_HIDDEN    signed Q1.7 weights; weight k = weights_i[8k+7:8k]
//  bias_i          in   8               signed Q1.7 bias
//  out_valid_o     out  1               neuron_o/fire_o valid
//  out_ready_i     in   1               consumer takes the result
//  neuron_o        out  10              result, unsigned Q3.7, ReLU'd and saturated
//  fire_o          out  1               neuron_o >= THRESH
//  busy_o          out  1               state != IDLE
// BEHAVIOUR
//  Reset (rst_i=1 at a clock edge): state=IDLE; idx=0; acc=0; all outputs 0. Reset overrides everything else.
//  Reset aborts any in-progress inference and discards it.
//  FSM, all transitions on the clock edge:
//   IDLE: hidden_ready_o=0. On start_i=1: clear acc and idx, go to ACCUM.
//   ACCUM: hidden_ready_o=1. A beat is accepted when hidden_valid_i && hidden_ready_o.
//     On accept: acc += prod(hidden_i, weight[idx]); idx++.
//     On the accept where idx==NUM_HIDDEN-1, go to FINISH.
//     With no valid, hold the state indefinitely.
//   FINISH: hidden_ready_o=0.
//     Compute sum = acc + (sext(bias_i) << 7).
//     Register neuron_o = (sum<=0) ? 0 : min(sum>>>7, 1023), truncating the 7 LSBs.
//     Register fire_o = (neuron_o value >= THRESH).
//     Set out_valid_o=1 and go to DONE.
//   DONE: hold neuron_o, fire_o and out_valid_o stable.
//     On out_ready_i=1: out_valid_o=0, go to IDLE. neuron_o and fire_o keep their last value.
//  start_i is ignored outside IDLE. DONE->IDLE and a new start take separate cycles (no same-cycle restart).
//  Arithmetic:
//   prod = $signed({1'b0,hidden_i}) * $signed(weight[idx]); 19-bit signed, Q4.14.
//   acc is signed, ACC_W = 19 + $clog2(NUM_HIDDEN) + 1 bits; it never overflows.
//  weights_i and bias_i are sampled when used; the upstream holds them stable from start_i until out_valid_o.
//  Latency: if the last beat is accepted at edge k, out_valid_o is high after edge k+1.
//  Minimum inference = 1 (start) + NUM_HIDDEN + 1 (finish) cycles, plus the DONE handshake.
//  hidden_i is ignored whenever hidden_ready_o=0.
// TESTING (NUM_HIDDEN=4, THRESH=64)
//  1. hidden=128 x4, weights=+64 each, bias=0 -> neuron_o=256, fire_o=1.
//     out_valid_o rises 1 edge after the 4th accept.
//  2. hidden=128 x4, weights=-64 each, bias=0 -> neuron_o=0, fire_o=0 (ReLU).
//  3. hidden=1023 x4, weights=+127 each, bias=+127 -> neuron_o=1023 (saturated), fire_o=1.
//  4. hidden=0 x4, bias=+64 -> neuron_o=64, fire_o=1.
//     Same with bias=+63 -> neuron_o=63, fire_o=0 (threshold boundary).
//  5. Gaps in hidden_valid_i between beats, and out_ready_i held low 5 cycles in DONE:
//     - results match test 1;
//     - outputs stay stable while waiting;
//     - start_i pulses while busy are ignored.
//  6. rst_i=1 after 2 accepted beats -> next cycle state=IDLE, all outputs 0.
//     A fresh test-1 inference afterwards yields neuron_o=256.

Source files
------------

// File: rtl/output_neuron_mac.sv
// Output-layer neuron: serial multiply-accumulate over NUM_HIDDEN hidden activations,
// then bias add, ReLU and saturation to unsigned Q3.7, presented on a valid/ready port
// together with a threshold "fire" flag.
module output_neuron_mac #(
  parameter int         NUM_HIDDEN = 4,
  parameter logic [9:0] THRESH     = 10'd64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      hidden_valid_i,
  output logic                      hidden_ready_o,
  input  logic [9:0]                hidden_i,
  input  logic [8*NUM_HIDDEN-1:0]   weights_i,
  input  logic [7:0]                bias_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [9:0]                neuron_o,
  output logic                      fire_o,
  output logic                      busy_o
);

  localparam int IDX_W = $clog2(NUM_HIDDEN);
  localparam int ACC_W = 19 + $clog2(NUM_HIDDEN) + 1;
  localparam int SUM_W = ACC_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HIDDEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_FINISH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // ReLU then drop the 7 fractional Q4.14 bits and clamp to the 10-bit Q3.7 range.
  function automatic logic [9:0] relu_sat(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] sh;
    sh = s >>> 7;
    if (s[SUM_W-1] || (s == '0))
      relu_sat = 10'd0;
    else if (|sh[SUM_W-1:10])
      relu_sat = 10'h3FF;
    else
      relu_sat = sh[9:0];
  endfunction

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [9:0]               neuron_q, neuron_d;
  logic                     fire_q, fire_d;
  logic                     out_valid_q, out_valid_d;

  logic [7:0]               wgt_sel;
  logic signed [18:0]       hid_x;
  logic signed [18:0]       wgt_x;
  logic signed [18:0]       prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [SUM_W-1:0]  acc_ext;
  logic signed [SUM_W-1:0]  bias_ext;
  logic signed [SUM_W-1:0]  sum;

  // Product of the current activation (zero-extended) and its signed weight, plus the biased sum.
  always_comb begin
    wgt_sel  = weights_i[{idx_q, 3'b000} +: 8];
    hid_x    = {9'b0, hidden_i};
    wgt_x    = {{11{wgt_sel[7]}}, wgt_sel};
    prod     = hid_x * wgt_x;
    prod_ext = {{(ACC_W-19){prod[18]}}, prod};
    acc_ext  = {acc_q[ACC_W-1], acc_q};
    bias_ext = {{(SUM_W-15){bias_i[7]}}, bias_i, 7'b0};
    sum      = acc_ext + bias_ext;
  end

  // Next-state and datapath updates for the IDLE -> ACCUM -> FINISH -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    neuron_d    = neuron_q;
    fire_d      = fire_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (hidden_valid_i) begin
          acc_d = acc_q + prod_ext;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX)
            state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        neuron_d    = relu_sat(sum);
        fire_d      = (neuron_d >= THRESH);
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset aborts any inference and clears every output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      neuron_q    <= '0;
      fire_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      neuron_q    <= neuron_d;
      fire_q      <= fire_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign hidden_ready_o = (state_q == S_ACCUM);
  assign busy_o         = (state_q != S_IDLE);
  assign out_valid_o    = out_valid_q;
  assign neuron_o       = neuron_q;
  assign fire_o         = fire_q;

endmodule

// File: tb/tb_output_neuron_mac.sv
// Bench for output_neuron_mac: transaction-level reference model plus a per-cycle compare process,
// directed scenarios with literal expectations, and a randomized inference loop.
module tb_output_neuron_mac;

  localparam int N  = 4;
  localparam int TH = 64;

  logic           clk = 1'b0;
  logic           rst, start, hv, hr, ov, ordy, fire, busy;
  logic [9:0]     hidden, neuron;
  logic [8*N-1:0] weights;
  logic [7:0]     bias;

  always #5 clk = ~clk;

  output_neuron_mac #(.NUM_HIDDEN(N), .THRESH(10'd64)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .hidden_valid_i(hv), .hidden_ready_o(hr), .hidden_i(hidden),
    .weights_i(weights), .bias_i(bias),
    .out_valid_o(ov), .out_ready_i(ordy),
    .neuron_o(neuron), .fire_o(fire), .busy_o(busy)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the real-valued definition.
  function automatic int ref_neuron(input int total);
    if (total <= 0) return 0;
    if (total / 128 > 1023) return 1023;
    return total / 128;
  endfunction

  // Model phases: 0 waiting for start, 1 collecting beats, 2 result due, 3 result presented.
  int m_phase  = 0;
  int m_prods[$];
  int m_neuron = 0;
  int m_fire   = 0;
  int m_valid  = 0;
  int m_sum;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_neuron = 0; m_fire = 0; m_valid = 0;
      m_prods.delete();
    end else begin
      case (m_phase)
        0: if (start) begin m_prods.delete(); m_phase = 1; end
        1: if (hv) begin
             m_prods.push_back(int'(hidden) * int'($signed(weights[8*m_prods.size() +: 8])));
             if (m_prods.size() == N) m_phase = 2;
           end
        2: begin
             m_sum = int'($signed(bias)) * 128;
             foreach (m_prods[i]) m_sum += m_prods[i];
             m_neuron = ref_neuron(m_sum);
             m_fire   = (m_neuron >= TH) ? 1 : 0;
             m_valid  = 1;
             m_phase  = 3;
           end
        3: if (ordy) begin m_valid = 0; m_phase = 0; end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", hr, (m_phase == 1));
      check("busy", busy, (m_phase != 0));
      check("out_valid", ov, m_valid);
      check("neuron", neuron, m_neuron);
      check("fire", fire, m_fire);
    end
  end

  task automatic run_inf(input int h[N], input logic [8*N-1:0] w, input logic [7:0] b,
                         input int gap_max, input int hold, input bit noise,
                         output int n_out, output int f_out, output int lat);
    weights = w;
    bias    = b;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < N; k++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        hv = 1'b0; hidden = 10'($urandom);
        if (noise) start = 1'($urandom_range(1, 0));
        @(negedge clk);
      end
      start = 1'b0; hv = 1'b1; hidden = 10'(h[k]);
      @(negedge clk);
      hv = 1'b0; hidden = 10'($urandom);
    end
    lat = 0;
    while (!ov && lat < 10) begin @(negedge clk); lat++; end
    n_out = int'(neuron);
    f_out = int'(fire);
    repeat (hold) begin
      ordy = 1'b0; hv = 1'($urandom_range(1, 0)); hidden = 10'($urandom);
      if (noise) start = 1'($urandom_range(1, 0));
      @(negedge clk);
    end
    start = 1'b0; hv = 1'b0; ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
  endtask

  int h[N];
  int n_o, f_o, lat;

  initial begin
    rst = 1'b1; start = 1'b0; hv = 1'b0; hidden = '0; weights = '0; bias = '0; ordy = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_valid", ov, 0);
    check("rst_neuron", neuron, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", hr, 0);
    rst = 1'b0;

    // 1: positive weights
    h = '{128, 128, 128, 128};
    run_inf(h, {4{8'h40}}, 8'h00, 0, 1, 1'b0, n_o, f_o, lat);
    check("t1_neuron", n_o, 256);
    check("t1_fire", f_o, 1);
    check("t1_latency", lat, 1);
    check("t1_model", m_neuron, 256);

    // 2: negative weights, ReLU clamps to zero
    run_inf(h, {4{8'hC0}}, 8'h00, 0, 1, 1'b0, n_o, f_o, lat);
    check("t2_neuron", n_o, 0);
    check("t2_fire", f_o, 0);

    // 3: saturation
    h = '{1023, 1023, 1023, 1023};
    run_inf(h, {4{8'h7F}}, 8'h7F, 0, 1, 1'b0, n_o, f_o, lat);
    check("t3_neuron", n_o, 1023);
    check("t3_fire", f_o, 1);

    // 4: threshold boundary driven by bias alone
    h = '{0, 0, 0, 0};
    run_inf(h, {4{8'h55}}, 8'd64, 0, 1, 1'b0, n_o, f_o, lat);
    check("t4a_neuron", n_o, 64);
    check("t4a_fire", f_o, 1);
    run_inf(h, {4{8'h55}}, 8'd63, 0, 1, 1'b0, n_o, f_o, lat);
    check("t4b_neuron", n_o, 63);
    check("t4b_fire", f_o, 0);

    // 5: gaps, stalled consumer, spurious start pulses
    h = '{128, 128, 128, 128};
    run_inf(h, {4{8'h40}}, 8'h00, 3, 5, 1'b1, n_o, f_o, lat);
    check("t5_neuron", n_o, 256);
    check("t5_fire", f_o, 1);
    check("t5_latency", lat, 1);
    check("t5_held", neuron, 256);

    // 6: reset after two accepted beats
    weights = {4{8'h40}}; bias = 8'h00;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) begin hv = 1'b1; hidden = 10'd128; @(negedge clk); end
    hv = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_valid", ov, 0);
    check("t6_neuron", neuron, 0);
    check("t6_fire", fire, 0);
    check("t6_ready", hr, 0);
    rst = 1'b0;
    run_inf(h, {4{8'h40}}, 8'h00, 0, 1, 1'b0, n_o, f_o, lat);
    check("t6_rerun", n_o, 256);

    // Randomized inferences, checked cycle by cycle against the model
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < N; k++) h[k] = int'($urandom_range(1023, 0));
      run_inf(h, 32'($urandom), 8'($urandom), 3, int'($urandom_range(4, 0)), 1'b1, n_o, f_o, lat);
      check("rand_latency", lat, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
